lbp_host: RTL and testbench

Memory-side responder for the LBP engine's gray-read / LBP-write interface. Holds a 128×128 gray image loaded over a streaming port and serves zero-latency gray reads. Captures every LBP write into result memory. After `finish`, streams the result image out for checking. Used as the bench/system-level counterpart of the LBP engine and as the reusable image host for later contest blocks.

---
 rtl/lbp_pkg.sv | 20 ++
 rtl/lbp_host_ram.sv | 28 ++
 rtl/lbp_host.sv | 136 +++++++++++++
 tb/tb_lbp_host.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// lbp_pkg: constants and types shared by the LBP image host and the LBP engine.
//   WIDTH      - image side in pixels (square image)
//   DATA_WIDTH - pixel / LBP word width
//   ADDR_WIDTH - pixel address width, address = {row, col}
//   DEPTH      - pixels per image
//   host_state_t - host sequencing states
package lbp_pkg;
  localparam int WIDTH      = 128;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = WIDTH * WIDTH;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SERVE,
    DUMP,
    DONE
  } host_state_t;
endpackage

// File: rtl/lbp_host_ram.sv
// lbp_host_ram: DEPTH x DW storage, synchronous write, asynchronous read.
//   clk       - clock
//   we_i      - write enable
//   waddr_i   - write address
//   wdata_i   - write data
//   raddr_i   - read address
//   rdata_o   - read data, combinational from raddr_i
// Contents are never reset.
module lbp_host_ram #(
  parameter int DEPTH = 16384,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/lbp_host.sv
// lbp_host: memory-side responder for the LBP engine.
// Loads a gray image over a streaming port, serves zero-latency gray reads,
// captures LBP writes (with a per-pixel "written" bitmap and a write count),
// then streams the result image out.
// Ports:
//   clk, reset (async, active-low)
//   start                              - begins a load from IDLE/DONE
//   load_valid/load_data/load_ready    - raster-order image load
//   gray_ready/gray_req/gray_addr/gray_data - engine read port (same-cycle data)
//   lbp_valid/lbp_addr/lbp_data        - engine write port
//   finish                             - engine completion, starts the dump
//   dump_valid/dump_ready/dump_addr/dump_data/dump_written - result stream
//   wr_cnt                             - accepted LBP writes since load (saturating)
//   done                               - dump complete
module lbp_host
  import lbp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  gray_ready,
  input  logic                  gray_req,
  input  logic [ADDR_WIDTH-1:0] gray_addr,
  output logic [DATA_WIDTH-1:0] gray_data,
  input  logic                  lbp_valid,
  input  logic [ADDR_WIDTH-1:0] lbp_addr,
  input  logic [DATA_WIDTH-1:0] lbp_data,
  input  logic                  finish,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_written,
  output logic [ADDR_WIDTH:0]   wr_cnt,
  output logic                  done
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  host_state_t           state_q;
  logic [ADDR_WIDTH-1:0] load_cnt_q;
  logic [ADDR_WIDTH-1:0] dump_addr_q;
  logic [ADDR_WIDTH:0]   wr_cnt_q;
  logic [DEPTH-1:0]      written_q;

  logic                  start_load;
  logic                  load_beat;
  logic                  lbp_wr;
  logic [DATA_WIDTH-1:0] gray_rd;
  logic [DATA_WIDTH-1:0] lbp_rd;

  // Outputs are pure decodes of the state register, so they drop the
  // instant reset is asserted.
  assign load_ready = (state_q == LOAD);
  assign gray_ready = (state_q == SERVE);
  assign dump_valid = (state_q == DUMP);
  assign done       = (state_q == DONE);

  assign start_load = start && ((state_q == IDLE) || (state_q == DONE));
  assign load_beat  = load_ready && load_valid;
  assign lbp_wr     = gray_ready && lbp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      dump_addr_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            dump_addr_q <= '0;
            wr_cnt_q    <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (load_cnt_q == LAST_ADDR) state_q <= SERVE;
            else load_cnt_q <= load_cnt_q + 1'b1;
          end
        end
        SERVE: begin
          // A write coincident with finish is still accepted.
          if (lbp_valid && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
          if (finish) begin
            state_q     <= DUMP;
            dump_addr_q <= '0;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_addr_q == LAST_ADDR) state_q <= DONE;
            else dump_addr_q <= dump_addr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Written bitmap: not reset (like the memories); it only becomes visible in
  // DUMP, which can only be reached after a start has cleared it.
  always_ff @(posedge clk) begin
    if (start_load) written_q <= '0;
    else if (lbp_wr) written_q[lbp_addr] <= 1'b1;
  end

  lbp_host_ram #(.DEPTH(DEPTH), .DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_gray_mem (
    .clk     (clk),
    .we_i    (load_beat),
    .waddr_i (load_cnt_q),
    .wdata_i (load_data),
    .raddr_i (gray_addr),
    .rdata_o (gray_rd)
  );

  lbp_host_ram #(.DEPTH(DEPTH), .DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_lbp_mem (
    .clk     (clk),
    .we_i    (lbp_wr),
    .waddr_i (lbp_addr),
    .wdata_i (lbp_data),
    .raddr_i (dump_addr_q),
    .rdata_o (lbp_rd)
  );

  assign gray_data    = (gray_ready && gray_req) ? gray_rd : '0;
  assign dump_addr    = dump_addr_q;
  assign dump_data    = dump_valid ? lbp_rd : '0;
  assign dump_written = dump_valid && written_q[dump_addr_q];
  assign wr_cnt       = wr_cnt_q;
endmodule

// File: tb/tb_lbp_host.sv
module tb_lbp_host;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        gray_ready;
  logic        gray_req = 1'b0;
  logic [13:0] gray_addr = '0;
  logic [7:0]  gray_data;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [13:0] dump_addr;
  logic [7:0]  dump_data;
  logic        dump_written;
  logic [14:0] wr_cnt;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lbp_host dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_written(dump_written),
    .wr_cnt(wr_cnt), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic lbp_write(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    lbp_valid = 1'b1; lbp_addr = a; lbp_data = d;
    @(posedge clk);
    #1 lbp_valid = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  initial begin
    int i;
    int exp_addr;

    // Reset held low for 3 cycles, read request active to prove gating.
    gray_req = 1'b1; gray_addr = 14'h0081;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_dump_addr", dump_addr, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_gray_data", gray_data, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_dump_written", dump_written, 0);
    gray_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_load_ready", load_ready, 0);

    // Start pulse.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_load_ready", load_ready, 1);
    $display("start -> load_ready=%0b", load_ready);

    // Load ramp with random gaps; a start during LOAD must be ignored.
    i = 0;
    while (i < DEPTH) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        start = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data = i[7:0];
        start = (i == 100);
        if (i == DEPTH - 1) chk("gray_ready_before_last", gray_ready, 0);
        i++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0; start = 1'b0;
    chk("gray_ready_after_last", gray_ready, 1);
    chk("load_ready_after_last", load_ready, 0);
    $display("load complete gray_ready=%0b", gray_ready);

    // Zero-latency reads.
    gray_req = 1'b1; gray_addr = 14'h0081; #1;
    chk("gray_0081", gray_data, 8'h81);
    gray_addr = 14'h1234; #1;
    chk("gray_1234", gray_data, 8'h34);
    gray_addr = 14'h3FFF; #1;
    chk("gray_3fff", gray_data, 8'hFF);
    gray_req = 1'b0; #1;
    chk("gray_noreq", gray_data, 0);

    // LBP writes, including overwrites at the same address.
    lbp_write(14'h3F7E, 8'hA5);
    lbp_write(14'h3F7E, 8'hA5);
    lbp_write(14'h3F7E, 8'h3C);
    @(negedge clk);
    chk("wr_cnt_3", wr_cnt, 3);
    lbp_write(14'h0005, 8'h55);

    // Write coincident with finish.
    @(negedge clk);
    lbp_valid = 1'b1; lbp_addr = 14'h0000; lbp_data = 8'h11; finish = 1'b1;
    @(negedge clk);
    lbp_valid = 1'b0; finish = 1'b0;
    chk("finish_gray_ready", gray_ready, 0);
    chk("finish_dump_valid", dump_valid, 1);
    chk("finish_wr_cnt", wr_cnt, 5);
    gray_req = 1'b1; gray_addr = 14'h0081; #1;
    chk("dump_gray_ignored", gray_data, 0);
    gray_req = 1'b0;
    // Writes outside SERVE must be ignored.
    lbp_valid = 1'b1; lbp_addr = 14'h3F7E; lbp_data = 8'h00;
    @(negedge clk);
    lbp_valid = 1'b0;
    chk("dump_wr_ignored_cnt", wr_cnt, 5);
    chk("dump_addr_start", dump_addr, 0);
    chk("dump_data_0", dump_data, 8'h11);
    chk("dump_written_0", dump_written, 1);
    $display("dump begin addr=%h data=%h", dump_addr, dump_data);

    // Dump with dump_ready toggling.
    exp_addr = 0;
    for (int c = 0; c < 20; c++) begin
      dump_ready = c[0];
      chk("toggle_dump_addr", dump_addr, exp_addr);
      if (exp_addr == 1) chk("dump_written_1", dump_written, 0);
      if (exp_addr == 5) begin
        chk("dump_data_5", dump_data, 8'h55);
        chk("dump_written_5", dump_written, 1);
      end
      @(posedge clk);
      if (dump_ready) exp_addr++;
      @(negedge clk);
    end
    $display("toggle phase dump_addr=%h", dump_addr);

    // Remainder of the dump at full rate.
    dump_ready = 1'b1;
    while (exp_addr < DEPTH) begin
      if (exp_addr == 16'h3F7E) begin
        chk("dump_addr_3f7e", dump_addr, 14'h3F7E);
        chk("dump_data_3f7e", dump_data, 8'h3C);
        chk("dump_written_3f7e", dump_written, 1);
      end
      if (exp_addr == DEPTH - 1) begin
        chk("dump_addr_last", dump_addr, 14'h3FFF);
        chk("dump_written_last", dump_written, 0);
        chk("done_before_last", done, 0);
      end
      @(posedge clk);
      exp_addr++;
      @(negedge clk);
    end
    dump_ready = 1'b0;
    chk("done_after_dump", done, 1);
    chk("dump_valid_after_dump", dump_valid, 0);
    repeat (2) @(negedge clk);
    chk("done_held", done, 1);
    $display("dump complete done=%0b", done);

    // DONE -> LOAD on start; counters and bitmap cleared.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_load_ready", load_ready, 1);
    chk("restart_done", done, 0);
    chk("restart_wr_cnt", wr_cnt, 0);
    chk("load_gray_ready", gray_ready, 0);

    // Full-rate reload, then dump to address 500 and reset mid-dump.
    load_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      load_data = k[7:0];
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk("reload_gray_ready", gray_ready, 1);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("redump_written_0", dump_written, 0);
    dump_ready = 1'b1;
    for (int k = 0; k < 500; k++) @(posedge clk);
    @(negedge clk);
    dump_ready = 1'b0;
    chk("redump_addr_500", dump_addr, 500);
    $display("dump paused addr=%0d", dump_addr);

    reset = 1'b0; #1;
    chk("async_dump_valid", dump_valid, 0);
    chk("async_done", done, 0);
    chk("async_dump_addr", dump_addr, 0);
    chk("async_dump_data", dump_data, 0);
    chk("async_load_ready", load_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", load_ready | dump_valid | gray_ready | done, 0);
    $display("reset mid-dump -> idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
